// File: rtl/cmd_sequencer_if.sv
// Command channel from the packet sequencer to the vector execute unit.
// The master drives the command fields; the slave answers with ready.
interface cmd_sequencer_if;
    logic       valid;
    logic       ready;
    logic [3:0] op;
    logic [3:0] vreg;
    logic [7:0] len;

    modport master (output valid, output op, output vreg, output len, input ready);
    modport slave  (input valid, input op, input vreg, input len, output ready);
endinterface

// File: rtl/cmd_sequencer.sv
// Parses host command packets from the receive FIFO. LOAD payloads go to the vector
// register file; every other opcode is issued as a single command over valid/ready.
module cmd_sequencer #(
    parameter int MAX_LEN = 16,
    parameter int TIMEOUT = 10_000
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic                            in_ready_i,
    input  logic [7:0]                      in_data_i,
    output logic                            in_read_o,
    output logic                            vec_we_o,
    output logic [4+$clog2(MAX_LEN)-1:0]    vec_addr_o,
    output logic [7:0]                      vec_wdata_o,
    cmd_sequencer_if.master                 cmd,
    output logic                            busy_o,
    output logic                            err_pulse_o,
    output logic [1:0]                      err_code_o
);
    localparam int EW = $clog2(MAX_LEN);
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [7:0]    MAX_LEN_B = 8'(MAX_LEN);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 1);
    localparam logic [3:0]    OP_LOAD   = 4'd1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LEN   = 2'd1,
        S_DATA  = 2'd2,
        S_ISSUE = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [3:0]        op_q, op_d;
    logic [3:0]        reg_q, reg_d;
    logic [7:0]        len_q, len_d;
    logic [EW-1:0]     idx_q, idx_d;
    logic [TW-1:0]     tmo_q, tmo_d;
    logic              we_q, we_d;
    logic [4+EW-1:0]   addr_q, addr_d;
    logic [7:0]        wdata_q, wdata_d;
    logic              err_pulse_q, err_pulse_d;
    logic [1:0]        err_code_q, err_code_d;
    logic              consume_s;
    logic              last_elem_s;

    // A byte is popped whenever the FIFO has one and the parser is not issuing
    assign consume_s   = in_ready_i & ~rst_i & (state_q != S_ISSUE);
    assign last_elem_s = ((8'(idx_q) + 8'd1) == len_q);

    assign in_read_o   = consume_s;
    assign vec_we_o    = we_q;
    assign vec_addr_o  = addr_q;
    assign vec_wdata_o = wdata_q;
    assign cmd.valid   = (state_q == S_ISSUE);
    assign cmd.op      = op_q;
    assign cmd.vreg    = reg_q;
    assign cmd.len     = len_q;
    assign busy_o      = (state_q != S_IDLE);
    assign err_pulse_o = err_pulse_q;
    assign err_code_o  = err_code_q;

    // Packet parser: next state, latched fields, write strobe and error reporting
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        reg_d       = reg_q;
        len_d       = len_q;
        idx_d       = idx_q;
        tmo_d       = tmo_q;
        we_d        = 1'b0;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        err_pulse_d = 1'b0;
        err_code_d  = err_code_q;
        case (state_q)
            S_IDLE: begin
                tmo_d = '0;
                if (consume_s) begin
                    op_d  = in_data_i[7:4];
                    reg_d = in_data_i[3:0];
                    if (in_data_i[7:4] == 4'd0) begin
                        err_pulse_d = 1'b1;
                        err_code_d  = 2'd2;
                    end else begin
                        state_d = S_LEN;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LEN: begin
                if (consume_s) begin
                    len_d = in_data_i;
                    tmo_d = '0;
                    idx_d = '0;
                    if ((in_data_i == 8'd0) || (in_data_i > MAX_LEN_B)) begin
                        err_pulse_d = 1'b1;
                        err_code_d  = 2'd1;
                        state_d     = S_IDLE;
                    end else if (op_q == OP_LOAD) begin
                        state_d = S_DATA;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    err_pulse_d = 1'b1;
                    err_code_d  = 2'd3;
                    tmo_d       = '0;
                    state_d     = S_IDLE;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            S_DATA: begin
                if (consume_s) begin
                    we_d    = 1'b1;
                    addr_d  = {reg_q, idx_q};
                    wdata_d = in_data_i;
                    idx_d   = idx_q + EW'(1);
                    tmo_d   = '0;
                    if (last_elem_s) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_DATA;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    err_pulse_d = 1'b1;
                    err_code_d  = 2'd3;
                    tmo_d       = '0;
                    state_d     = S_IDLE;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            S_ISSUE: begin
                tmo_d = '0;
                if (cmd.ready) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_ISSUE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            op_q        <= 4'd0;
            reg_q       <= 4'd0;
            len_q       <= 8'd0;
            idx_q       <= '0;
            tmo_q       <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= 8'd0;
            err_pulse_q <= 1'b0;
            err_code_q  <= 2'd0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            reg_q       <= reg_d;
            len_q       <= len_d;
            idx_q       <= idx_d;
            tmo_q       <= tmo_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            err_pulse_q <= err_pulse_d;
            err_code_q  <= err_code_d;
        end
    end
endmodule

// File: tb/tb_cmd_sequencer.sv
// Bench for cmd_sequencer: cycle tables, hand-written corner sequences and a
// randomized byte stream checked against a packet-level reference parser.
module tb_cmd_sequencer;
    localparam int MAX_LEN = 16;
    localparam int TIMEOUT = 10_000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_ready = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_read;
    logic       vec_we;
    logic [7:0] vec_addr;
    logic [7:0] vec_wdata;
    logic       busy;
    logic       err_pulse;
    logic [1:0] err_code;

    cmd_sequencer_if cmd_if();

    cmd_sequencer #(.MAX_LEN(MAX_LEN), .TIMEOUT(TIMEOUT)) dut (
        .clk_i(clk), .rst_i(rst), .in_ready_i(in_ready), .in_data_i(in_data),
        .in_read_o(in_read), .vec_we_o(vec_we), .vec_addr_o(vec_addr),
        .vec_wdata_o(vec_wdata), .cmd(cmd_if), .busy_o(busy),
        .err_pulse_o(err_pulse), .err_code_o(err_code)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic       rdy;
        logic [7:0] d;
        logic       rd;
        logic       we;
        logic [7:0] addr;
        logic [7:0] wd;
        logic       busy;
        logic       ep;
        logic [1:0] ec;
    } vec_t;

    vec_t        tbl[$];
    logic [7:0]  stream[$];
    logic [7:0]  fifo[$];
    logic [31:0] expq[$];
    logic [31:0] obsq[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
        total++;
        if (act !== exp_v) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp_v);
        end
    endtask

    // apply inputs for one cycle, then wait for the sampling point
    task automatic drive(input logic rdy, input logic [7:0] d, input logic crdy);
        in_ready     = rdy;
        in_data      = d;
        cmd_if.ready = crdy;
        @(negedge clk);
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string nm);
        chk(nm, {25'd0, in_read, vec_we, vec_addr, vec_wdata, cmd_if.valid, cmd_if.op,
                 cmd_if.vreg, cmd_if.len, busy, err_pulse, err_code}, 64'd0);
    endtask

    function automatic vec_t mk(input logic rdy, input logic [7:0] d, input logic rd,
                                input logic we, input logic [7:0] a, input logic [7:0] wd,
                                input logic bz, input logic ep, input logic [1:0] ec);
        vec_t v;
        v.rdy = rdy; v.d = d; v.rd = rd; v.we = we; v.addr = a; v.wd = wd;
        v.busy = bz; v.ep = ep; v.ec = ec;
        return v;
    endfunction

    // reference parser: packet rules applied to the whole byte stream
    function automatic void parse();
        int         i;
        logic [3:0] op;
        logic [3:0] r;
        logic [7:0] len;
        i = 0;
        while (i < stream.size()) begin
            op = stream[i][7:4];
            r  = stream[i][3:0];
            if (op == 4'd0) begin
                expq.push_back({8'h03, 22'd0, 2'd2});
                i = i + 1;
            end else begin
                len = stream[i+1];
                if (len == 8'd0 || int'(len) > MAX_LEN) begin
                    expq.push_back({8'h03, 22'd0, 2'd1});
                    i = i + 2;
                end else if (op == 4'd1) begin
                    for (int k = 0; k < int'(len); k++)
                        expq.push_back({8'h01, 8'h00, r, 4'(k), stream[i+2+k]});
                    i = i + 2 + int'(len);
                end else begin
                    expq.push_back({8'h02, op, r, len, 8'h00});
                    i = i + 2;
                end
            end
        end
    endfunction

    initial begin
        int n_err;
        int wr;
        int xfer;
        int viol;
        int cyc;
        logic done;
        logic pop;

        // reset state
        cmd_if.ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        drive(1'b0, 8'h00, 1'b0);
        chk_zero("reset_outputs");
        rst = 1'b0;
        adv();

        // LOAD back-to-back, bad header resync, bad lengths
        tbl.push_back(mk(1'b1, 8'h13, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 2'd0));
        tbl.push_back(mk(1'b1, 8'h03, 1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 2'd0));
        tbl.push_back(mk(1'b1, 8'hAA, 1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 2'd0));
        tbl.push_back(mk(1'b1, 8'hBB, 1'b1, 1'b1, 8'h30, 8'hAA, 1'b1, 1'b0, 2'd0));
        tbl.push_back(mk(1'b1, 8'hCC, 1'b1, 1'b1, 8'h31, 8'hBB, 1'b1, 1'b0, 2'd0));
        tbl.push_back(mk(1'b0, 8'h00, 1'b0, 1'b1, 8'h32, 8'hCC, 1'b0, 1'b0, 2'd0));
        tbl.push_back(mk(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 2'd0));
        tbl.push_back(mk(1'b1, 8'h0F, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 2'd0));
        tbl.push_back(mk(1'b1, 8'h12, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 2'd2));
        tbl.push_back(mk(1'b1, 8'h02, 1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 2'd2));
        tbl.push_back(mk(1'b1, 8'h55, 1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 2'd2));
        tbl.push_back(mk(1'b1, 8'h66, 1'b1, 1'b1, 8'h20, 8'h55, 1'b1, 1'b0, 2'd2));
        tbl.push_back(mk(1'b0, 8'h00, 1'b0, 1'b1, 8'h21, 8'h66, 1'b0, 1'b0, 2'd2));
        tbl.push_back(mk(1'b1, 8'h11, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 2'd2));
        tbl.push_back(mk(1'b1, 8'h00, 1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 2'd2));
        tbl.push_back(mk(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 2'd1));
        tbl.push_back(mk(1'b1, 8'h11, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 2'd1));
        tbl.push_back(mk(1'b1, 8'h11, 1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 2'd1));
        tbl.push_back(mk(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 2'd1));
        tbl.push_back(mk(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 2'd1));
        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].rdy, tbl[i].d, 1'b1);
            chk($sformatf("tbl%0d_in_read", i), 64'(in_read), 64'(tbl[i].rd));
            chk($sformatf("tbl%0d_vec_we", i), 64'(vec_we), 64'(tbl[i].we));
            if (tbl[i].we) begin
                chk($sformatf("tbl%0d_addr", i), 64'(vec_addr), 64'(tbl[i].addr));
                chk($sformatf("tbl%0d_wdata", i), 64'(vec_wdata), 64'(tbl[i].wd));
            end
            chk($sformatf("tbl%0d_busy", i), 64'(busy), 64'(tbl[i].busy));
            chk($sformatf("tbl%0d_cmd_valid", i), 64'(cmd_if.valid), 64'd0);
            chk($sformatf("tbl%0d_err_pulse", i), 64'(err_pulse), 64'(tbl[i].ep));
            chk($sformatf("tbl%0d_err_code", i), 64'(err_code), 64'(tbl[i].ec));
            adv();
        end

        // command held under backpressure
        drive(1'b1, 8'h25, 1'b0); adv();
        drive(1'b1, 8'h08, 1'b0); adv();
        for (int k = 0; k < 20; k++) begin
            drive(1'b1, 8'h37, 1'b0);
            chk("bp_held", {in_read, cmd_if.valid, cmd_if.op, cmd_if.vreg, cmd_if.len, busy},
                {1'b0, 1'b1, 4'd2, 4'd5, 8'd8, 1'b1});
            adv();
        end
        xfer = 0;
        drive(1'b1, 8'h37, 1'b1);
        if (cmd_if.valid && cmd_if.ready) xfer++;
        chk("bp_xfer_in_read", 64'(in_read), 64'd0);
        adv();
        drive(1'b0, 8'h00, 1'b1);
        if (cmd_if.valid && cmd_if.ready) xfer++;
        chk("bp_xfers", 64'(xfer), 64'd1);
        chk("bp_after", {cmd_if.valid, busy}, 64'd0);
        adv();

        // inter-byte timeout in DATA
        drive(1'b1, 8'h14, 1'b1); adv();
        drive(1'b1, 8'h04, 1'b1); adv();
        drive(1'b1, 8'h01, 1'b1); adv();
        n_err = 0;
        wr = 0;
        for (int n = 1; n <= 2 * TIMEOUT && n_err == 0; n++) begin
            drive(1'b0, 8'h00, 1'b1);
            if (vec_we) wr++;
            if (err_pulse) begin
                n_err = n;
                chk("tmo_code", 64'(err_code), 64'd3);
                chk("tmo_busy", 64'(busy), 64'd0);
            end
            adv();
        end
        chk("tmo_cycle", 64'(n_err), 64'(TIMEOUT + 1));
        chk("tmo_writes", 64'(wr), 64'd1);
        drive(1'b1, 8'h26, 1'b1); adv();
        drive(1'b1, 8'h01, 1'b1);
        chk("lat_len_read", 64'(in_read), 64'd1);
        adv();
        drive(1'b0, 8'h00, 1'b1);
        chk("lat_valid", {cmd_if.valid, cmd_if.op, cmd_if.vreg, cmd_if.len, busy},
            {1'b1, 4'd2, 4'd6, 8'd1, 1'b1});
        adv();
        drive(1'b0, 8'h00, 1'b1);
        chk("lat_idle", {cmd_if.valid, busy}, 64'd0);
        adv();

        // reset mid-DATA, mid-ISSUE, then a clean packet
        drive(1'b1, 8'h17, 1'b1); adv();
        drive(1'b1, 8'h05, 1'b1); adv();
        drive(1'b1, 8'h01, 1'b1); adv();
        drive(1'b1, 8'h02, 1'b1); adv();
        rst = 1'b1;
        drive(1'b0, 8'h00, 1'b1); adv();
        rst = 1'b0;
        drive(1'b0, 8'h00, 1'b1);
        chk_zero("rst_mid_data");
        adv();
        drive(1'b1, 8'h23, 1'b0); adv();
        drive(1'b1, 8'h02, 1'b0); adv();
        drive(1'b0, 8'h00, 1'b0);
        chk("pre_rst_valid", 64'(cmd_if.valid), 64'd1);
        rst = 1'b1;
        adv();
        rst = 1'b0;
        drive(1'b0, 8'h00, 1'b0);
        chk_zero("rst_mid_issue");
        adv();
        drive(1'b1, 8'h31, 1'b1); adv();
        drive(1'b1, 8'h04, 1'b1); adv();
        drive(1'b0, 8'h00, 1'b1);
        chk("post_rst_cmd", {cmd_if.valid, cmd_if.op, cmd_if.vreg, cmd_if.len},
            {1'b1, 4'd3, 4'd1, 8'd4});
        adv();

        // randomized packet stream against the reference parser
        for (int p = 0; p < 40; p++) begin
            int unsigned kind;
            logic [3:0] r;
            logic [7:0] len;
            kind = $urandom_range(0, 3);
            r    = 4'($urandom_range(0, 15));
            if (kind == 0) begin
                len = 8'($urandom_range(1, MAX_LEN));
                stream.push_back({4'd1, r});
                stream.push_back(len);
                for (int k = 0; k < int'(len); k++) stream.push_back(8'($urandom_range(0, 255)));
            end else if (kind == 1) begin
                stream.push_back({4'($urandom_range(2, 15)), r});
                stream.push_back(8'($urandom_range(1, MAX_LEN)));
            end else if (kind == 2) begin
                stream.push_back({4'd0, r});
            end else begin
                stream.push_back({4'($urandom_range(1, 15)), r});
                stream.push_back(($urandom_range(0, 1) == 0) ? 8'd0 : 8'($urandom_range(MAX_LEN + 1, 255)));
            end
        end
        parse();
        fifo = stream;
        viol = 0;
        cyc  = 0;
        done = 1'b0;
        while (!done && cyc < 20000) begin
            cyc++;
            in_ready     = (fifo.size() != 0) && ($urandom_range(0, 3) != 0);
            in_data      = (fifo.size() != 0) ? fifo[0] : 8'h00;
            cmd_if.ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (in_read && !in_ready) viol++;
            if (vec_we) obsq.push_back({8'h01, 8'h00, vec_addr, vec_wdata});
            if (cmd_if.valid && cmd_if.ready)
                obsq.push_back({8'h02, cmd_if.op, cmd_if.vreg, cmd_if.len, 8'h00});
            if (err_pulse) obsq.push_back({8'h03, 22'd0, err_code});
            pop = in_read;
            if (fifo.size() == 0 && !busy) done = 1'b1;
            adv();
            if (pop) void'(fifo.pop_front());
        end
        in_ready = 1'b0;
        chk("rand_drained", 64'(done), 64'd1);
        chk("rand_read_gate", 64'(viol), 64'd0);
        chk("rand_event_count", 64'(obsq.size()), 64'(expq.size()));
        for (int i = 0; i < expq.size() && i < obsq.size(); i++)
            chk($sformatf("rand_event%0d", i), 64'(obsq[i]), 64'(expq[i]));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
